// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU operation encoding used by the requesters, the arbiter and the ALU.
package alu_share_arbiter_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_ops_t;

endpackage

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters: arbitration, issue register, tagged response register.
// Build option ALU_ARB_FIXED_PRIO_EN: fixed priority (requester 0 highest) instead of round-robin.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  alu_ops_t        req_op [NREQ],
  input  logic [31:0]     req_a  [NREQ],
  input  logic [31:0]     req_b  [NREQ],
  output alu_ops_t        alu_op,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  input  logic [31:0]     alu_out,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [IDW-1:0]  resp_id,
  output logic [31:0]     resp_data
);

  localparam int unsigned DW = 32;

  logic           iss_v;
  alu_ops_t       iss_op;
  logic [DW-1:0]  iss_a;
  logic [DW-1:0]  iss_b;
  logic [IDW-1:0] iss_id;
  logic [IDW-1:0] last_id;

  logic           adv;
  logic           iss_free;
  logic           accept;
  logic [IDW-1:0] gnt;

  assign adv      = iss_v && (!resp_valid || resp_ready);
  assign iss_free = !iss_v || adv;
  assign accept   = iss_free && (|req_valid);

  // Grant selection: gnt is meaningful only when some request is valid.
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    logic [IDW-1:0] cand;
    gnt  = '0;
    cand = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      cand = IDW'(i);
      if (req_valid[cand]) gnt = cand;
    end
  end
`else
  always_comb begin
    logic           found;
    logic [IDW-1:0] cand;
    int unsigned    idx;
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx  = (32'(last_id) + k) % NREQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
  end
`endif

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_ready
    assign req_ready[g] = iss_free && req_valid[g] && (gnt == IDW'(g));
  end

  // Idle issue stage presents a harmless ADD 0+0 to the ALU.
  assign alu_op = iss_v ? iss_op : ALU_ADD;
  assign alu_a  = iss_v ? iss_a  : '0;
  assign alu_b  = iss_v ? iss_b  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v   <= 1'b0;
      iss_op  <= ALU_ADD;
      iss_a   <= '0;
      iss_b   <= '0;
      iss_id  <= '0;
      last_id <= IDW'(NREQ - 1);
    end else if (accept) begin
      iss_v   <= 1'b1;
      iss_op  <= req_op[gnt];
      iss_a   <= req_a[gnt];
      iss_b   <= req_b[gnt];
      iss_id  <= gnt;
      last_id <= gnt;
    end else if (adv) begin
      iss_v   <= 1'b0;
    end
  end

  // Response register reloads on advance, otherwise empties when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else if (adv) begin
      resp_valid <= 1'b1;
      resp_id    <= iss_id;
      resp_data  <= alu_out;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, directed corner sequences, randomized scoreboard.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int IW = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  alu_ops_t       req_op [N];
  logic [31:0]    req_a  [N];
  logic [31:0]    req_b  [N];
  alu_ops_t       alu_op;
  logic [31:0]    alu_a, alu_b, alu_out;
  logic           resp_valid, resp_ready;
  logic [IW-1:0]  resp_id;
  logic [31:0]    resp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(alu_ops_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return 32'($signed(a) >>> b[4:0]);
      default: return a + b;
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_a, alu_b);

  alu_share_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_resp(input string nm, input logic v, input int id, input logic [31:0] d);
    chk({nm, "_valid"}, 32'(resp_valid), 32'(v));
    if (v) begin
      chk({nm, "_id"}, 32'(resp_id), 32'(id));
      chk({nm, "_data"}, resp_data, d);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_op[i] = ALU_ADD;
      req_a[i]  = '0;
      req_b[i]  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Reference arbitration: cyclic search after the last winner, or lowest index in fixed mode.
  function automatic int model_grant(logic [N-1:0] v, int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
    return 0;
  endfunction

  typedef struct {
    int          id;
    alu_ops_t    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] d;
  } item_t;

  initial begin
    vec_t  vt [8];
    int    ord [4];
    item_t fl [$];
    int    pres, m_last, g;
    logic  iss_has, adv, fire;
    logic [N-1:0] exp_rdy, acc_prev;

    vt[0] = '{0, ALU_SUB, 32'd5,          32'hFFFF_FFFD, 32'd8};
    vt[1] = '{1, ALU_ADD, 32'd1,          32'd1,         32'd2};
    vt[2] = '{0, ALU_AND, 32'hFF00_FF00,  32'h0F0F_0F0F, 32'h0F00_0F00};
    vt[3] = '{1, ALU_OR,  32'h1234_0000,  32'h0000_5678, 32'h1234_5678};
    vt[4] = '{0, ALU_SLL, 32'd1,          32'd31,        32'h8000_0000};
    vt[5] = '{1, ALU_SRL, 32'h8000_0000,  32'd4,         32'h0800_0000};
    vt[6] = '{0, ALU_SRA, 32'h8000_0000,  32'd4,         32'hF800_0000};
    vt[7] = '{1, ALU_XOR, 32'hF0F0_F0F0,  32'hFFFF_FFFF, 32'h0F0F_0F0F};
`ifdef ALU_ARB_FIXED_PRIO_EN
    ord = '{0, 0, 0, 0};
`else
    ord = '{0, 1, 0, 1};
`endif

    // Reset values, observed while reset is held.
    rst_n = 1'b0;
    drive_idle();
    resp_ready = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_req_ready", 32'(req_ready), 0);

    // Single request with one-cycle issue latency.
    do_reset();
    req_valid = 2'b01; req_op[0] = ALU_SUB; req_a[0] = 32'd5; req_b[0] = 32'hFFFF_FFFD;
    resp_ready = 1'b1;
    @(negedge clk); chk("single_ready", 32'(req_ready), 1);
    step(); req_valid = '0;
    @(negedge clk);
    chk("single_inflight_v", 32'(resp_valid), 0);
    chk("single_alu_a", alu_a, 5);
    chk("single_alu_op", 32'(alu_op), 32'(ALU_SUB));
    step();
    @(negedge clk); chk_resp("single_resp", 1'b1, 0, 32'd8);
    step();

    // Two requesters contending for four cycles.
    do_reset();
    resp_ready = 1'b1;
    req_op[0] = ALU_ADD; req_a[0] = 1; req_b[0] = 1;
    req_op[1] = ALU_ADD; req_a[1] = 2; req_b[1] = 2;
    req_valid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) req_valid = '0;
      @(negedge clk);
      if (c < 4) chk("rr_grant", 32'(req_ready), 32'(1 << ord[c]));
      if (c >= 2) chk_resp("rr_resp", 1'b1, ord[c-2], (ord[c-2] == 0) ? 32'd2 : 32'd4);
      step();
    end

    // Vector table, one isolated request per entry.
    for (int v = 0; v < 8; v++) begin
      req_valid = '0;
      req_valid[vt[v].id] = 1'b1;
      req_op[vt[v].id] = vt[v].op; req_a[vt[v].id] = vt[v].a; req_b[vt[v].id] = vt[v].b;
      @(negedge clk); chk("vec_ready", 32'(req_ready), 32'(1 << vt[v].id));
      step(); req_valid = '0;
      @(negedge clk); chk("vec_alu_a", alu_a, vt[v].a);
      step();
      @(negedge clk); chk_resp("vec_resp", 1'b1, vt[v].id, vt[v].exp);
      step();
    end

    // Backpressure: fill both stages, then drain in order.
    resp_ready = 1'b0;
    req_valid = 2'b10; req_op[1] = ALU_SRA; req_a[1] = 32'h8000_0000; req_b[1] = 32'd4;
    @(negedge clk); chk("bp_ready1", 32'(req_ready), 32'b10);
    step();
    req_valid = 2'b01; req_op[0] = ALU_XOR; req_a[0] = 32'hF0F0_F0F0; req_b[0] = 32'hFFFF_FFFF;
    @(negedge clk); chk("bp_ready0", 32'(req_ready), 32'b01);
    step();
    req_valid = 2'b11;
    repeat (2) begin
      @(negedge clk);
      chk("bp_full_ready", 32'(req_ready), 0);
      chk("bp_full_alu_a", alu_a, 32'hF0F0_F0F0);
      chk_resp("bp_full_resp", 1'b1, 1, 32'hF800_0000);
      step();
    end
    req_valid = '0; resp_ready = 1'b1;
    @(negedge clk); chk_resp("bp_drain1", 1'b1, 1, 32'hF800_0000);
    step();
    @(negedge clk); chk_resp("bp_drain0", 1'b1, 0, 32'h0F0F_0F0F);
    step();
    @(negedge clk); chk("bp_empty", 32'(resp_valid), 0);
    step();

    // Streaming from one requester at full rate.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        req_valid = 2'b01; req_op[0] = ALU_ADD; req_a[0] = 32'(c); req_b[0] = 32'd100;
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (c < 8) chk("stream_ready", 32'(req_ready), 1);
      if (c >= 2) chk_resp("stream_resp", 1'b1, 0, 32'(100 + c - 2));
      step();
    end

    // Idle drive.
    drive_idle();
    repeat (5) begin
      @(negedge clk);
      chk("idle_alu_op", 32'(alu_op), 32'(ALU_ADD));
      chk("idle_alu_a", alu_a, 0);
      chk("idle_alu_b", alu_b, 0);
      chk("idle_resp_valid", 32'(resp_valid), 0);
      step();
    end

    // Reset with both stages full.
    resp_ready = 1'b0;
    req_valid = 2'b01; req_op[0] = ALU_ADD; req_a[0] = 7; req_b[0] = 7;
    step();
    req_valid = 2'b10; req_op[1] = ALU_ADD; req_a[1] = 9; req_b[1] = 1;
    step();
    req_valid = '0;
    @(negedge clk);
    chk("mid_full_v", 32'(resp_valid), 1);
    chk("mid_full_alu_a", alu_a, 9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 0);
    chk("mid_rst_alu_a", alu_a, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    resp_ready = 1'b1;
    req_valid = 2'b11; req_op[0] = ALU_ADD; req_a[0] = 3; req_b[0] = 4;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'b01);
    chk("post_rst_no_stale", 32'(resp_valid), 0);
    step(); req_valid = '0;
    @(negedge clk); chk("post_rst_no_stale2", 32'(resp_valid), 0);
    step();
    @(negedge clk); chk_resp("post_rst_resp", 1'b1, 0, 32'd7);
    step();
    @(negedge clk); chk("post_rst_done", 32'(resp_valid), 0);

    // Randomized traffic against the transaction-queue model.
    do_reset();
    m_last = N - 1; pres = 0; acc_prev = '0;
    fl.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !acc_prev[i]) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_op[i] = alu_ops_t'($urandom_range(0, 7));
          req_a[i] = $urandom;
          req_b[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      iss_has = (fl.size() > pres);
      adv = iss_has && ((pres == 0) || resp_ready);
      exp_rdy = '0;
      g = model_grant(req_valid, m_last);
      if ((!iss_has || adv) && (|req_valid)) exp_rdy[g] = 1'b1;
      chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_resp_valid", 32'(resp_valid), 32'(pres));
      if (pres == 1 && fl.size() > 0) begin
        chk("rnd_resp_id", 32'(resp_id), 32'(fl[0].id));
        chk("rnd_resp_data", resp_data, fl[0].d);
      end
      fire = (pres == 1) && resp_ready;
      if (fire) void'(fl.pop_front());
      pres = adv ? 1 : (fire ? 0 : pres);
      if (exp_rdy != '0) begin
        fl.push_back('{g, alu_f(req_op[g], req_a[g], req_b[g])});
        m_last = g;
      end
      acc_prev = exp_rdy;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
